// File: rtl/ram_param_pkg.sv
// Shared types and default sizes for the ram_param block.
package ram_param_pkg;

    // Default geometry: 32-bit words, 32 locations.
    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 5;

    // Clear sequencer states: CLEAR zeroes the array after reset, IDLE serves accesses.
    typedef enum logic {
        StClear = 1'b0,
        StIdle  = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_param_clr.sv
// Clear sequencer for ram_param: after reset, walks every address once and
// strobes a zero write into each, holding busy high for exactly 2**ADDR_W cycles.
module ram_param_clr
    import ram_param_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);

    ram_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // State and counter registers; reset restarts the clear from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: advance the counter while clearing, leave after the last address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                cnt_d = '0;
            end
        endcase
    end

    // Outputs: the zero-write strobe is active for every CLEAR cycle.
    always_comb begin
        busy     = (state_q == StClear);
        clr_we   = (state_q == StClear);
        clr_addr = cnt_q;
    end

endmodule

// File: rtl/ram_param.sv
// Single-port byte-writable RAM with registered read (latency 1) and a
// self-clear sequence after reset.
// Optional macro RAM_PARAM_BYPASS_EN adds a write-first, byte-accurate bypass
// for a read that follows a write to the same address on the previous cycle.
module ram_param
    import ram_param_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                wena,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                busy
);

    localparam int unsigned NumBytes = DATA_W / 8;
    localparam int unsigned Depth    = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];

    logic              clr_busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              wr_req;
    logic              rd_req;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    ram_param_clr #(
        .ADDR_W (ADDR_W)
    ) u_clr (
        .clk      (clk),
        .rst      (rst),
        .busy     (clr_busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    // Requests are only honoured in IDLE and never on a reset edge.
    always_comb begin
        wr_req = ena & wena & ~clr_busy & ~rst;
        rd_req = ena & ~wena & ~clr_busy & ~rst;
    end

    // Storage: zero writes from the sequencer, otherwise byte-masked user writes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_req) begin
            for (int unsigned i = 0; i < NumBytes; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef RAM_PARAM_BYPASS_EN
    logic                wr_hit_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [NumBytes-1:0] wr_be_q;
    logic [DATA_W-1:0]   wr_data_q;

    // Remember the previous cycle's write so a following read can take its bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_hit_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_be_q   <= '0;
            wr_data_q <= '0;
        end else begin
            wr_hit_q  <= wr_req;
            wr_addr_q <= addr;
            wr_be_q   <= be;
            wr_data_q <= wdata;
        end
    end

    // Read word: array contents with freshly written bytes merged over them.
    always_comb begin
        rd_word = mem_q[addr];
        if (wr_hit_q && (wr_addr_q == addr)) begin
            for (int unsigned i = 0; i < NumBytes; i++) begin
                if (wr_be_q[i]) begin
                    rd_word[8*i +: 8] = wr_data_q[8*i +: 8];
                end
            end
        end
    end
`else
    // Read word: plain array contents at the read edge.
    always_comb begin
        rd_word = mem_q[addr];
    end
`endif

    // Read register next state: capture on a read, otherwise hold.
    always_comb begin
        rvalid_d = rd_req;
        rdata_d  = rd_req ? rd_word : rdata_q;
    end

    // Read register; reset drops any read issued on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign busy   = clr_busy;

endmodule

// File: tb/tb_ram_param.sv
// Directed self-checking bench for ram_param at default geometry (32 x 32 bits).
module tb_ram_param;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        wena;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        busy;

    int n_cmp;
    int n_err;

    ram_param u_dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .wena   (wena),
        .be     (be),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena  = 1'b0;
        wena = 1'b0;
        be   = 4'h0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        ena   = 1'b1;
        wena  = 1'b1;
        addr  = a;
        wdata = d;
        be    = b;
        step();
    endtask

    // Issue a read, then check the registered result one cycle later.
    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        ena  = 1'b1;
        wena = 1'b0;
        addr = a;
        step();
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check(tag, rdata, exp);
    endtask

    initial begin
        int  n;
        logic rv_seen;

        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        ena   = 1'b0;
        wena  = 1'b0;
        be    = 4'h0;
        addr  = '0;
        wdata = '0;

        // Reset state
        step();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;

        // Clear length, with a write and a read attempted while busy
        n = 0;
        rv_seen = 1'b0;
        while (busy && n < 100) begin
            n++;
            idle();
            if (n == 2) begin
                ena = 1'b1; wena = 1'b1; addr = 5'd5; wdata = 32'hDEADBEEF; be = 4'hF;
            end else if (n == 4) begin
                ena = 1'b1; wena = 1'b0; addr = 5'd5;
            end
            step();
            if (rvalid) rv_seen = 1'b1;
        end
        check("clr_busy_cycles", 32'(n), 32'd32);
        check("clr_no_rvalid", 32'(rv_seen), 32'd0);

        // Whole array reads zero, back to back
        for (int i = 0; i < 32; i++) begin
            ena  = 1'b1;
            wena = 1'b0;
            addr = 5'(i);
            step();
            check($sformatf("zero_rvalid_%0d", i), 32'(rvalid), 32'd1);
            check($sformatf("zero_rdata_%0d", i), rdata, 32'h0);
        end
        idle();
        step();
        check("idle_rvalid", 32'(rvalid), 32'd0);
        check("idle_rdata_hold", rdata, 32'h0);
        rd_chk("busy_ignore_a5", 5'd5, 32'h0);

        // Byte enables
        wr(5'd3, 32'hAABBCCDD, 4'hF);
        wr(5'd3, 32'h11223344, 4'b0101);
        rd_chk("be_merge", 5'd3, 32'hAA22CC44);
        idle();
        step();
        check("hold_rvalid", 32'(rvalid), 32'd0);
        check("hold_rdata", rdata, 32'hAA22CC44);

        // Back-to-back read latency
        wr(5'd1, 32'h1, 4'hF);
        wr(5'd2, 32'h2, 4'hF);
        wr(5'd3, 32'h3, 4'hF);
        rd_chk("b2b_a1", 5'd1, 32'h1);
        rd_chk("b2b_a2", 5'd2, 32'h2);
        rd_chk("b2b_a3", 5'd3, 32'h3);

        // be=0 write and ena=0 write leave memory untouched
        wr(5'd2, 32'hFFFFFFFF, 4'h0);
        ena = 1'b0; wena = 1'b1; addr = 5'd1; wdata = 32'hFFFFFFFF; be = 4'hF;
        step();
        check("ena0_rvalid", 32'(rvalid), 32'd0);
        rd_chk("be0_keep", 5'd2, 32'h2);
        rd_chk("ena0_keep", 5'd1, 32'h1);

        // Write then read same address on the next cycle (both builds yield new data)
        wr(5'd7, 32'h12345678, 4'hF);
        rd_chk("wr_rd_a7", 5'd7, 32'h12345678);
        wr(5'd7, 32'hAABBCCDD, 4'b0011);
        rd_chk("wr_rd_a7_bytes", 5'd7, 32'h1234CCDD);

        // Top address
        wr(5'd31, 32'hCAFEF00D, 4'hF);
        idle();
        step();
        rd_chk("top_addr", 5'd31, 32'hCAFEF00D);
        rd_chk("a0_untouched", 5'd0, 32'h0);

        // Reset on the same edge as a read drops it
        ena = 1'b1; wena = 1'b0; addr = 5'd31; rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        check("rst_rd_rvalid", 32'(rvalid), 32'd0);
        check("rst_rd_rdata", rdata, 32'h0);
        check("rst_rd_busy", 32'(busy), 32'd1);

        // Reset at clear cycle 10 restarts the full clear
        n = 0;
        repeat (10) begin
            if (busy) n++;
            step();
        end
        check("midclr_pre", 32'(n), 32'd10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        check("midclr_busy_cycles", 32'(n), 32'd32);
        rd_chk("midclr_a31_zero", 5'd31, 32'h0);
        rd_chk("midclr_a7_zero", 5'd7, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_param.md
RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 The block SHALL have port ena  input  1  access request; no access when low.
REQ-006 The block SHALL have port wena  input  1  1 = write, 0 = read; sampled only with ena=1.
REQ-007 The block SHALL have port be  input  DATA_W/8  byte enables for writes; bit i covers data bits [8i+7:8i].
REQ-008 The block SHALL have port addr  input  ADDR_W  word address.
REQ-009 The block SHALL have port wdata  input  DATA_W  write data; separate buses, no tristate.
REQ-010 The block SHALL have port rdata  output  DATA_W  registered read data.
REQ-011 The block SHALL have port rvalid  output  1  one-cycle pulse qualifying rdata.
REQ-012 The block SHALL have port busy  output  1  high while the clear sequence runs; requests are ignored.

Function
REQ-013 The block SHALL implement a two-state FSM: CLEAR (entered on reset) and IDLE.
REQ-014 In CLEAR, the block SHALL write zero to mem[cnt] each cycle, with cnt going 0..DEPTH-1; after writing DEPTH-1 it SHALL go to IDLE, so busy is high for exactly DEPTH cycles.
REQ-015 While busy=1, the block SHALL ignore ena/wena/be/addr/wdata, hold rvalid at 0 and leave rdata unchanged.
REQ-016 In IDLE with ena=1 and wena=1, the block SHALL update each byte i of mem[addr] to wdata byte i where be[i]=1 at the clock edge; be=0 leaves memory unchanged.
REQ-017 In IDLE with ena=1 and wena=0, the block SHALL present mem[addr] on rdata with rvalid=1 exactly one cycle later (latency 1).
REQ-018 rdata SHALL hold its last value whenever rvalid=0; back-to-back reads SHALL return one word per cycle.
REQ-019 With ena=0, the block SHALL leave memory unchanged and drive rvalid=0 on the next cycle.
REQ-020 Address handling SHALL have no bounds error: every ADDR_W value is a valid location.

Reset
REQ-021 On rst=1 at a clock edge, the block SHALL set state to CLEAR, cnt to 0, rdata to 0 and rvalid to 0, and busy SHALL read 1 from the following cycle.
REQ-022 Reset asserted mid-clear or mid-access SHALL restart the clear from address 0; any in-flight read SHALL be discarded (no rvalid).
REQ-023 Memory contents SHALL be defined (zero) only after the clear completes.

Configuration
REQ-024 Macro RAM_PARAM_BYPASS_EN, when defined, SHALL make a read that follows a write to the same address on the previous cycle return the newly written bytes (write-first, byte-accurate).
REQ-025 Without RAM_PARAM_BYPASS_EN, the block SHALL always return the memory array contents as of the read edge; no bypass path is present.

Structure
REQ-026 A shared package ram_param_pkg SHALL hold the FSM state enum (CLEAR, IDLE) and default width constants.
REQ-027 The block SHALL place the clear-sequencer FSM and counter in one sub-module, ram_param_clr, which outputs busy, the clear address and the clear write strobe.
REQ-028 The storage array and read register SHALL remain in ram_param.

Verification
REQ-029 Reset test: assert rst for 1 cycle -> busy=1 for exactly 32 cycles (defaults), then a read of addr 0..31 returns 0 with rvalid=1 one cycle after each request.
REQ-030 Byte-enable test: write 0xAABBCCDD to addr 3 with be=1111, then 0x11223344 with be=0101 -> a read of addr 3 returns 0xAA22CC44.
REQ-031 Latency test: back-to-back reads of addr 1, 2 and 3 holding 0x1, 0x2 and 0x3 -> rdata = 0x1, 0x2, 0x3 on the three following cycles with rvalid continuously 1.
REQ-032 Busy-ignore test: a write of 0xDEADBEEF to addr 5 issued in clear cycle 2 -> after the clear, addr 5 reads 0.
REQ-033 Reset mid-clear test: assert rst at clear cycle 10 -> busy stays high for 32 more cycles, counted from 0.
REQ-034 Bypass test: write 0x12345678 to addr 7, then read addr 7 on the next cycle -> with RAM_PARAM_BYPASS_EN the read returns 0x12345678; without it the result matches the array contents at the read edge.
